// File: rtl/wb_skid_stage.sv
// MEM/WB boundary: two-entry skid buffer holding writeback candidates.
// in_ready and out_valid come straight from flops.
module wb_skid_stage #(
   parameter int W  = 64,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_alu,
   input  logic [W-1:0]  in_mem,
   input  logic [W-1:0]  in_pc,
   input  logic [W-1:0]  in_imm,
   input  logic [1:0]    in_sel,
   input  logic          in_wr_en,
   input  logic [RW-1:0] in_wr_reg,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_alu,
   output logic [W-1:0]  out_mem,
   output logic [W-1:0]  out_pc,
   output logic [W-1:0]  out_imm,
   output logic [1:0]    out_sel,
   output logic          out_wr_en,
   output logic [RW-1:0] out_wr_reg,
   output logic [15:0]   stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [W-1:0]  alu;
      logic [W-1:0]  mem;
      logic [W-1:0]  pc;
      logic [W-1:0]  imm;
      logic [1:0]    sel;
      logic          wr_en;
      logic [RW-1:0] wr_reg;
   } entry_t;

   state_t state_q, state_d;
   entry_t in_e;
   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   logic   in_ready_q;
   logic   out_valid_q;
   logic   in_fire;
   logic   out_fire;

   assign in_e = {in_alu, in_mem, in_pc, in_imm,
                  in_sel, in_wr_en, in_wr_reg};

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid_q & out_ready;

   // Next state and entry moves; flush drops everything
   // and leaves the payload registers untouched.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (in_fire) begin
               state_d = ONE;
               main_d  = in_e;
            end
         end
         ONE: begin
            unique case ({in_fire, out_fire})
               2'b11: main_d = in_e;
               2'b10: begin
                  state_d = FULL;
                  skid_d  = in_e;
               end
               2'b01: state_d = EMPTY;
               default: ;
            endcase
         end
         FULL: begin
            if (out_fire) begin
               state_d = ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush) begin
         state_d = EMPTY;
         main_d  = main_q;
         skid_d  = skid_q;
      end
   end

   // State, handshake flops and entry storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         main_q      <= '0;
         skid_q      <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= (state_d != FULL);
         out_valid_q <= (state_d != EMPTY);
         main_q      <= main_d;
         skid_q      <= skid_d;
      end
   end

   // Saturating count of cycles the main entry waits.
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (out_valid_q && !out_ready && stall_cnt != 16'hFFFF)
         stall_cnt <= stall_cnt + 16'd1;
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_alu    = main_q.alu;
   assign out_mem    = main_q.mem;
   assign out_pc     = main_q.pc;
   assign out_imm    = main_q.imm;
   assign out_sel    = main_q.sel;
   assign out_wr_en  = main_q.wr_en & out_valid_q;
   assign out_wr_reg = main_q.wr_reg;

endmodule

// File: tb/tb_wb_skid_stage.sv
// Bench for wb_skid_stage: queue reference model,
// directed scenarios and randomized traffic.
module tb_wb_skid_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready;
   logic [63:0] in_alu, in_mem, in_pc, in_imm;
   logic [1:0]  in_sel;
   logic        in_wr_en;
   logic [4:0]  in_wr_reg;
   logic        out_valid, out_ready;
   logic [63:0] out_alu, out_mem, out_pc, out_imm;
   logic [1:0]  out_sel;
   logic        out_wr_en;
   logic [4:0]  out_wr_reg;
   logic [15:0] stall_cnt;

   always #5 clk = ~clk;

   wb_skid_stage #(.W(64), .RW(5)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu(in_alu), .in_mem(in_mem),
      .in_pc(in_pc), .in_imm(in_imm),
      .in_sel(in_sel), .in_wr_en(in_wr_en),
      .in_wr_reg(in_wr_reg),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_alu(out_alu), .out_mem(out_mem),
      .out_pc(out_pc), .out_imm(out_imm),
      .out_sel(out_sel), .out_wr_en(out_wr_en),
      .out_wr_reg(out_wr_reg), .stall_cnt(stall_cnt)
   );

   typedef struct {
      logic [63:0] alu, mem, pc, imm;
      logic [1:0]  sel;
      logic        wr_en;
      logic [4:0]  wr_reg;
   } ent_t;

   ent_t q[$];
   int   mcnt;
   bit   clean;
   int   checks = 0;
   int   errors = 0;

   task automatic check(string tag, logic [63:0] got,
                        logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic ent_t cur_in();
      ent_t e;
      e.alu = in_alu; e.mem = in_mem;
      e.pc = in_pc; e.imm = in_imm;
      e.sel = in_sel; e.wr_en = in_wr_en;
      e.wr_reg = in_wr_reg;
      return e;
   endfunction

   // one clock; model follows the FIFO rules
   task automatic tick();
      bit inf, outf;
      @(posedge clk);
      inf  = in_valid && (q.size() < 2);
      outf = (q.size() > 0) && out_ready;
      if (rst) begin
         q.delete();
         mcnt  = 0;
         clean = 1;
      end else begin
         if (q.size() > 0 && !out_ready && mcnt < 65535)
            mcnt++;
         if (flush) q.delete();
         else begin
            if (outf) void'(q.pop_front());
            if (inf) begin
               q.push_back(cur_in());
               clean = 0;
            end
         end
      end
      #1;
   endtask

   task automatic verify();
      check("in_ready", 64'(in_ready), 64'(q.size() < 2));
      check("out_valid", 64'(out_valid), 64'(q.size() > 0));
      check("stall_cnt", 64'(stall_cnt), 64'(mcnt));
      if (q.size() > 0) begin
         check("alu", out_alu, q[0].alu);
         check("mem", out_mem, q[0].mem);
         check("pc", out_pc, q[0].pc);
         check("imm", out_imm, q[0].imm);
         check("sel", 64'(out_sel), 64'(q[0].sel));
         check("wr_en", 64'(out_wr_en), 64'(q[0].wr_en));
         check("wr_reg", 64'(out_wr_reg), 64'(q[0].wr_reg));
      end else begin
         check("wr_en_idle", 64'(out_wr_en), 64'd0);
         if (clean) begin
            check("rst_alu", out_alu, 64'd0);
            check("rst_mem", out_mem, 64'd0);
            check("rst_pc", out_pc, 64'd0);
            check("rst_imm", out_imm, 64'd0);
            check("rst_sel", 64'(out_sel), 64'd0);
            check("rst_reg", 64'(out_wr_reg), 64'd0);
         end
      end
   endtask

   task automatic set_in(bit v, logic [63:0] a);
      in_valid  = v;
      in_alu    = a;
      in_mem    = ~a;
      in_pc     = a + 64'd4;
      in_imm    = a ^ 64'h5A5A_0000_1234_0000;
      in_sel    = a[1:0];
      in_wr_en  = ~a[0];
      in_wr_reg = a[4:0] + 5'd1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      verify();
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      set_in(1'b0, 64'd0);
      mcnt = 0; clean = 1;
      do_reset();
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);

      // first entry
      set_in(1'b1, 64'h1);
      in_sel = 2'd0; in_wr_en = 1'b1; in_wr_reg = 5'd3;
      out_ready = 1'b1;
      tick();
      set_in(1'b0, 64'd0);
      verify();
      check("first_alu", out_alu, 64'h1);
      check("first_wr_en", 64'(out_wr_en), 64'd1);
      check("first_reg", 64'(out_wr_reg), 64'd3);
      tick();
      verify();

      // streaming 0..7
      for (int i = 0; i < 8; i++) begin
         set_in(1'b1, 64'(i));
         tick();
         verify();
         check("stream_alu", out_alu, 64'(i));
         check("stream_rdy", 64'(in_ready), 64'd1);
      end
      set_in(1'b0, 64'd0);
      tick();
      verify();

      // stall and skid: A, B, C
      do_reset();
      out_ready = 1'b0;
      set_in(1'b1, 64'hA); tick(); verify();
      set_in(1'b1, 64'hB); tick(); verify();
      check("full_rdy", 64'(in_ready), 64'd0);
      check("hold_a", out_alu, 64'hA);
      set_in(1'b1, 64'hC);
      tick(); verify();
      tick(); verify();
      check("hold_a2", out_alu, 64'hA);
      check("stall3", 64'(stall_cnt), 64'd3);
      out_ready = 1'b1;
      tick(); verify();
      check("seq_b", out_alu, 64'hB);
      tick(); verify();
      check("seq_c", out_alu, 64'hC);
      set_in(1'b0, 64'd0);
      tick(); verify();
      check("drained", 64'(out_valid), 64'd0);
      check("stall_kept", 64'(stall_cnt), 64'd3);

      // flush while FULL with a pending input
      out_ready = 1'b0;
      set_in(1'b1, 64'h11); tick();
      set_in(1'b1, 64'h22); tick();
      verify();
      set_in(1'b1, 64'h33);
      flush = 1'b1; out_ready = 1'b1;
      tick();
      flush = 1'b0;
      set_in(1'b0, 64'd0);
      verify();
      check("fl_valid", 64'(out_valid), 64'd0);
      check("fl_rdy", 64'(in_ready), 64'd1);
      check("fl_wr_en", 64'(out_wr_en), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick(); verify();
      end

      // reset while FULL with sel=3 pending
      out_ready = 1'b0;
      set_in(1'b1, 64'h47); tick();
      set_in(1'b1, 64'h4B); tick();
      in_sel = 2'b11;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_in(1'b0, 64'd0);
      verify();
      check("rs_sel", 64'(out_sel), 64'd0);
      check("rs_alu", out_alu, 64'd0);
      check("rs_stall", 64'(stall_cnt), 64'd0);

      // randomized traffic
      for (int i = 0; i < 2500; i++) begin
         rst       = ($urandom_range(0, 149) == 0);
         flush     = ($urandom_range(0, 24) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = ($urandom_range(0, 2) != 0);
         in_alu    = {$urandom, $urandom};
         in_mem    = {$urandom, $urandom};
         in_pc     = {$urandom, $urandom};
         in_imm    = {$urandom, $urandom};
         in_sel    = 2'($urandom);
         in_wr_en  = 1'($urandom);
         in_wr_reg = 5'($urandom);
         tick();
         verify();
      end
      rst = 1'b0; flush = 1'b0;

      // stall counter saturation
      do_reset();
      out_ready = 1'b0;
      set_in(1'b1, 64'h99); tick();
      set_in(1'b0, 64'd0);
      for (int i = 0; i < 70000; i++) tick();
      verify();
      check("sat", 64'(stall_cnt), 64'hFFFF);
      tick();
      check("sat_hold", 64'(stall_cnt), 64'hFFFF);
      check("sat_alu", out_alu, 64'h99);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_skid_stage.md
Name: wb_skid_stage

Overview:
- MEM/WB pipeline boundary with valid/ready handshaking.
- Captures the four 64-bit writeback candidates (ALU result, load data, PC+4, immediate), the 2-bit writeback select and the register-write controls.
- Presents them registered to the downstream 4:1 64-bit writeback mux and register file.
- A 2-entry skid buffer (main + skid) keeps in_ready fully registered, so it is never combinationally dependent on out_ready.

Parameters:
- W, 64, datapath width of each candidate.
- RW, 5, register-specifier width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- flush  input  1  synchronous pipeline flush; discards all held entries
- in_valid  input  1  upstream entry valid
- in_ready  output  1  stage can accept (registered)
- in_alu  input  W  ALU result candidate (mux inA)
- in_mem  input  W  load data candidate (mux inB)
- in_pc  input  W  PC+4 candidate (mux inC)
- in_imm  input  W  immediate candidate (mux inD)
- in_sel  input  2  writeback select
- in_wr_en  input  1  register write enable
- in_wr_reg  input  RW  destination register
- out_valid  output  1  main entry valid
- out_ready  input  1  downstream accepts this cycle
- out_alu, out_mem, out_pc, out_imm  output  W each  main-entry candidates to the writeback mux
- out_sel  output  2  main-entry select to the writeback mux
- out_wr_en  output  1  main.wr_en AND out_valid
- out_wr_reg  output  RW  main-entry destination
- stall_cnt  output  16  cycles with out_valid=1 and out_ready=0; saturates at 16'hFFFF

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Entry = {alu, mem, pc, imm, sel, wr_en, wr_reg}.
- State machine (registered):
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main valid, out_valid=1, in_ready=1.
  - FULL: main and skid valid, out_valid=1, in_ready=0.
- EMPTY transitions:
  - in_fire -> ONE; main <= input.
  - Otherwise stay.
- ONE transitions:
  - in_fire & out_fire -> ONE; main <= input.
  - in_fire & !out_fire -> FULL; skid <= input, main unchanged.
  - !in_fire & out_fire -> EMPTY.
  - Otherwise stay; main held.
- FULL transitions:
  - out_fire -> ONE; main <= skid.
  - Otherwise stay. in_valid is ignored because in_ready=0.
- Ordering: strict FIFO order; no entry is dropped or duplicated except by flush or rst.
- Latency: 1 cycle from in_fire into EMPTY to out_valid=1. Sustained throughput of 1 entry/cycle while out_ready=1.
- Output stability: out_* payload changes only on a main load. While out_valid=1 and out_ready=0, all out_* are stable.
- Flush: next state EMPTY regardless of the current state.
  - Any in_fire or out_fire in the flush cycle has no effect on state.
  - The payload registers are not required to clear.
  - out_wr_en=0 the following cycle because out_valid=0.
- rst dominates flush. After rst: state EMPTY, in_ready=1, out_valid=0, all out_* payload = 0, out_sel=2'b00, out_wr_en=0, stall_cnt=0.
- Reset mid-operation discards both entries.
- stall_cnt:
  - Increments when out_valid & !out_ready, with saturation.
  - Clears only on rst; flush does not clear it.
- Width rules: no arithmetic on the payload; fields pass bit-exact.

Test Plan:
- Reset, then in_valid=1 with in_alu=64'h1, in_sel=0, in_wr_en=1, in_wr_reg=3 and out_ready=1 -> next cycle out_valid=1, out_alu=64'h1, out_wr_en=1, out_wr_reg=3; stall_cnt=0.
- Stream 8 entries, in_alu=0..7, with out_ready=1 every cycle -> outputs 0..7 on consecutive cycles; in_ready stays 1.
- Load A (alu=0xA), hold out_ready=0, send B (alu=0xB) -> FULL, in_ready=0, out_alu stays 0xA. Offered C is not accepted. Raise out_ready -> out sequence A, B, C; stall_cnt equals the number of stalled cycles.
- In FULL, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_wr_en=0; the flushed entries and the in-flight entry never appear.
- Assert rst while FULL with in_sel=2'b11 pending -> next cycle out_valid=0, out_sel=0, all out_* payload = 0, stall_cnt=0.
- Hold out_ready=0 with out_valid=1 for 70000 cycles -> stall_cnt saturates at 16'hFFFF.
